// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types for the core execution controller.
package cpu_run_ctrl_pkg;

  typedef enum logic [1:0] {
    RS_HALT  = 2'd0,
    RS_RUN   = 2'd1,
    RS_STEP  = 2'd2,
    RS_BREAK = 2'd3
  } run_state_t;

endpackage

// File: rtl/cpu_run_ctrl_edge_detect.sv
// Rising-edge detector; history resets to 1 so a level held through reset gives no edge.
module Edge_Detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic level_q;

  // Remember last cycle's level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_q <= 1'b1;
    else     level_q <= level;
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt/step/breakpoint controller producing the per-cycle commit enable,
// plus cycle and retired-instruction counters.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_btn,
  input  logic             step_btn,
  input  logic             halt_btn,
  input  logic             bp_en,
  input  logic [15:0]      bp_addr,
  input  logic [15:0]      pc,
  input  logic             is_halt,
  output logic             core_en,
  output logic [1:0]       state,
  output logic             bp_hit,
  output logic [CNT_W-1:0] cycles,
  output logic [CNT_W-1:0] retired
);

  run_state_t cur_st, nxt_st;
  logic run_rise, step_rise, halt_rise;
  logic bp_skip;
  logic bp_match, stop;

  Edge_Detect u_run_edge  (.clk(clk), .rst(rst), .level(run_btn),  .rise(run_rise));
  Edge_Detect u_step_edge (.clk(clk), .rst(rst), .level(step_btn), .rise(step_rise));
  Edge_Detect u_halt_edge (.clk(clk), .rst(rst), .level(halt_btn), .rise(halt_rise));

  assign bp_match = bp_en & (pc == bp_addr) & ~bp_skip;
  assign stop     = halt_rise | is_halt | bp_match;
  assign state    = cur_st;

  // Next-state and commit enable.
  always_comb begin
    nxt_st  = cur_st;
    core_en = 1'b0;
    unique case (cur_st)
      RS_HALT: begin
        if (run_rise)       nxt_st = RS_RUN;
        else if (step_rise) nxt_st = RS_STEP;
      end
      RS_RUN: begin
        core_en = ~stop;
        if (halt_rise | is_halt) nxt_st = RS_HALT;
        else if (bp_match)       nxt_st = RS_BREAK;
      end
      RS_STEP: begin
        core_en = ~is_halt;
        nxt_st  = RS_HALT;
      end
      RS_BREAK: begin
        if (halt_rise)      nxt_st = RS_HALT;
        else if (run_rise)  nxt_st = RS_RUN;
        else if (step_rise) nxt_st = RS_STEP;
      end
      default: nxt_st = RS_HALT;
    endcase
  end

  // State register and breakpoint-hit pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_st <= RS_HALT;
      bp_hit <= 1'b0;
    end else begin
      cur_st <= nxt_st;
      bp_hit <= (cur_st == RS_RUN) && (nxt_st == RS_BREAK);
    end
  end

  // Breakpoint skip: lets the breakpointed instruction commit once after resume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       bp_skip <= 1'b0;
    else if (nxt_st == RS_HALT || core_en)         bp_skip <= 1'b0;
    else if (cur_st == RS_BREAK && nxt_st == RS_RUN) bp_skip <= 1'b1;
  end

  // Saturating active-cycle counter and wrapping retired counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycles  <= '0;
      retired <= '0;
    end else begin
      if ((cur_st == RS_RUN || cur_st == RS_STEP) && cycles != '1)
        cycles <= cycles + 1'b1;
      if (core_en)
        retired <= retired + 1'b1;
    end
  end

endmodule
